decode_unit: RTL and testbench

- Stage directly downstream of fetch_unit.
- Captures fetch_unit's 9-bit instruction_val each cycle into an instruction register (IR) and decodes it into register/ALU control fields for the execute stage.
- Resolves JMP/BEZ and drives the branch_ctrl/branch_val pair back into fetch_unit.
- Squashes wrong-path instructions after a taken branch and stops issuing after HALT.

---
 rtl/decode_unit.sv | 176 +++++++++++++++++
 tb/tb_decode_unit.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_unit.sv
`default_nettype none
// ============================================================================
//  Module   : decode_unit
//  Purpose  : Instruction register and decoder placed after fetch_unit. It
//             resolves JMP/BEZ back to fetch, squashes wrong-path slots after
//             a taken branch and freezes issue once HALT is seen.
//  Options  : DECODE_BRANCH_STATS_EN adds saturating taken_count and
//             squash_count outputs, both STAT_W bits wide.
//  Revision : 1.0  initial release
// ============================================================================
module decode_unit #(
    parameter int FLUSH_CYCLES = 1,
    parameter int STAT_W       = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [8:0]  instruction_val,
    input  logic        zero_flag,
    output logic        branch_ctrl,
    output logic [7:0]  branch_val,
    output logic        valid,
    output logic [1:0]  alu_op,
    output logic [1:0]  rd,
    output logic [1:0]  rs,
    output logic [1:0]  rt,
    output logic [3:0]  imm,
    output logic        imm_sel,
    output logic        reg_we,
    output logic        halted
`ifdef DECODE_BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] taken_count,
    output logic [STAT_W-1:0] squash_count
`endif
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [2:0] OP_LDI  = 3'b100;
    localparam logic [2:0] OP_BEZ  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_SYS  = 3'b111;

    // Out-of-range parameters are rejected at elaboration time.
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_flush_cycles
        $error("decode_unit: FLUSH_CYCLES must be in 1..3");
    end
    if (STAT_W < 1) begin : g_bad_stat_w
        $error("decode_unit: STAT_W must be at least 1");
    end

    logic [8:0] r_ir;
    logic       r_ir_valid;
    logic [1:0] r_state;
    logic [1:0] r_flush_cnt;
    logic [1:0] w_state_nxt;
    logic [1:0] w_flush_nxt;

    logic [2:0] w_op;
    logic       w_is_jmp;
    logic       w_is_bez;
    logic       w_is_halt;
    logic       w_live;
    logic       w_taken;

    assign w_op      = r_ir[8:6];
    assign w_is_jmp  = (w_op == OP_JMP);
    assign w_is_bez  = (w_op == OP_BEZ);
    assign w_is_halt = (w_op == OP_SYS) && (r_ir[5:0] != 6'd0);
    // Only a captured instruction seen in RUN is architecturally live.
    assign w_live    = (r_state == S_RUN) && r_ir_valid;
    assign w_taken   = w_live && (w_is_jmp || (w_is_bez && zero_flag));

    // State register, instruction register and flush counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_RUN;
            r_flush_cnt <= 2'd0;
            r_ir        <= 9'h000;
            r_ir_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_nxt;
            if (r_state != S_HALT) begin
                r_ir       <= instruction_val;
                r_ir_valid <= 1'b1;
            end
        end
    end

    // Next-state logic: taken branch opens a flush window, HALT is terminal.
    always_comb begin
        w_state_nxt = r_state;
        w_flush_nxt = r_flush_cnt;
        case (r_state)
            S_RUN: begin
                if (w_taken) begin
                    w_state_nxt = S_FLUSH;
                    w_flush_nxt = 2'(FLUSH_CYCLES);
                end else if (w_live && w_is_halt) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt <= 2'd1) begin
                    w_state_nxt = S_RUN;
                    w_flush_nxt = 2'd0;
                end else begin
                    w_flush_nxt = r_flush_cnt - 2'd1;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_RUN;
                w_flush_nxt = 2'd0;
            end
        endcase
    end

    // Output decode from the registered IR and state.
    always_comb begin
        valid       = w_live;
        branch_ctrl = w_taken;
        halted      = (r_state == S_HALT);
        branch_val  = 8'h00;
        alu_op      = 2'b00;
        rd          = 2'd0;
        rs          = 2'd0;
        rt          = 2'd0;
        imm         = 4'd0;
        imm_sel     = 1'b0;
        if (w_is_jmp || w_is_bez) begin
            branch_val = {r_ir[5], r_ir[5], r_ir[5:0]};
        end
        if (!w_op[2]) begin
            alu_op = w_op[1:0];
            rd     = r_ir[5:4];
            rs     = r_ir[3:2];
            rt     = r_ir[1:0];
        end else if (w_op == OP_LDI) begin
            rd      = r_ir[5:4];
            imm     = r_ir[3:0];
            imm_sel = 1'b1;
        end
        reg_we = w_live && (w_op <= OP_LDI);
    end

`ifdef DECODE_BRANCH_STATS_EN
    logic [STAT_W-1:0] r_taken_count;
    logic [STAT_W-1:0] r_squash_count;

    // Saturating counters of redirects and squashed capture slots.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_taken_count  <= '0;
            r_squash_count <= '0;
        end else begin
            if (w_taken && (r_taken_count != '1)) begin
                r_taken_count <= r_taken_count + STAT_W'(1);
            end
            if ((r_state == S_FLUSH) && (r_squash_count != '1)) begin
                r_squash_count <= r_squash_count + STAT_W'(1);
            end
        end
    end

    assign taken_count  = r_taken_count;
    assign squash_count = r_squash_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_unit
//  Purpose  : Directed self-checking bench for decode_unit. With
//             DECODE_BRANCH_STATS_EN defined a second instance
//             (FLUSH_CYCLES=2, STAT_W=2) exercises the statistics counters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_unit;

    logic       clock;
    logic       reset;
    logic [8:0] instruction_val;
    logic       zero_flag;
    logic       branch_ctrl;
    logic [7:0] branch_val;
    logic       valid;
    logic [1:0] alu_op, rd, rs, rt;
    logic [3:0] imm;
    logic       imm_sel, reg_we, halted;

    int n_vec = 0;
    int n_err = 0;

    decode_unit #(.FLUSH_CYCLES(1), .STAT_W(8)) u_dut (
        .clock(clock), .reset(reset), .instruction_val(instruction_val),
        .zero_flag(zero_flag), .branch_ctrl(branch_ctrl), .branch_val(branch_val),
        .valid(valid), .alu_op(alu_op), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
        .imm_sel(imm_sel), .reg_we(reg_we), .halted(halted)
`ifdef DECODE_BRANCH_STATS_EN
        , .taken_count(), .squash_count()
`endif
    );

`ifdef DECODE_BRANCH_STATS_EN
    logic       s_branch_ctrl, s_valid, s_imm_sel, s_reg_we, s_halted;
    logic [7:0] s_branch_val;
    logic [1:0] s_alu_op, s_rd, s_rs, s_rt;
    logic [3:0] s_imm;
    logic [1:0] s_taken, s_squash;

    decode_unit #(.FLUSH_CYCLES(2), .STAT_W(2)) u_stats (
        .clock(clock), .reset(reset), .instruction_val(instruction_val),
        .zero_flag(zero_flag), .branch_ctrl(s_branch_ctrl), .branch_val(s_branch_val),
        .valid(s_valid), .alu_op(s_alu_op), .rd(s_rd), .rs(s_rs), .rt(s_rt), .imm(s_imm),
        .imm_sel(s_imm_sel), .reg_we(s_reg_we), .halted(s_halted),
        .taken_count(s_taken), .squash_count(s_squash)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        instruction_val = 9'h01B;
        zero_flag = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({valid, branch_ctrl, branch_val, halted, reg_we, alu_op, rd, rs, rt, imm, imm_sel} !== 25'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0",
                     {valid, branch_ctrl, branch_val, halted, reg_we, alu_op, rd, rs, rt, imm, imm_sel});
        end
        reset = 1'b1;
        tick();
        n_vec++;
        if ({valid, alu_op, rd, rs, rt, reg_we, branch_ctrl} !== {1'b1, 2'b00, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL first_add: got %b want %b", {valid, alu_op, rd, rs, rt, reg_we, branch_ctrl},
                     {1'b1, 2'b00, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0});
        end
    endtask

    task automatic test_alu();
        instruction_val = 9'h0A7;   // AND rd=2 rs=1 rt=3
        tick();
        n_vec++;
        if ({valid, alu_op, rd, rs, rt, reg_we, imm_sel} !== {1'b1, 2'b10, 2'd2, 2'd1, 2'd3, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL alu_and: got %b want %b", {valid, alu_op, rd, rs, rt, reg_we, imm_sel},
                     {1'b1, 2'b10, 2'd2, 2'd1, 2'd3, 1'b1, 1'b0});
        end
        instruction_val = 9'h0E4;   // OR rd=2 rs=1 rt=0
        tick();
        n_vec++;
        if ({valid, alu_op, rd, rs, rt, reg_we} !== {1'b1, 2'b11, 2'd2, 2'd1, 2'd0, 1'b1}) begin
            n_err++;
            $display("FAIL alu_or: got %b want %b", {valid, alu_op, rd, rs, rt, reg_we},
                     {1'b1, 2'b11, 2'd2, 2'd1, 2'd0, 1'b1});
        end
        instruction_val = 9'h05B;   // SUB rd=1 rs=2 rt=3
        tick();
        n_vec++;
        if ({valid, alu_op, rd, rs, rt, reg_we} !== {1'b1, 2'b01, 2'd1, 2'd2, 2'd3, 1'b1}) begin
            n_err++;
            $display("FAIL alu_sub: got %b want %b", {valid, alu_op, rd, rs, rt, reg_we},
                     {1'b1, 2'b01, 2'd1, 2'd2, 2'd3, 1'b1});
        end
    endtask

    task automatic test_jmp();
        instruction_val = 9'h194;   // JMP +20
        tick();
        n_vec++;
        if ({valid, branch_ctrl, branch_val, reg_we} !== {1'b1, 1'b1, 8'd20, 1'b0}) begin
            n_err++;
            $display("FAIL jmp_taken: got %h want %h", {valid, branch_ctrl, branch_val, reg_we},
                     {1'b1, 1'b1, 8'd20, 1'b0});
        end
        instruction_val = 9'h01B;   // wrong-path slot
        tick();
        n_vec++;
        if ({valid, branch_ctrl, reg_we} !== 3'b000) begin
            n_err++;
            $display("FAIL jmp_squash: got %b want 000", {valid, branch_ctrl, reg_we});
        end
        instruction_val = 9'h0E4;
        tick();
        n_vec++;
        if ({valid, branch_ctrl, alu_op} !== {1'b1, 1'b0, 2'b11}) begin
            n_err++;
            $display("FAIL jmp_resume: got %b want %b", {valid, branch_ctrl, alu_op}, {1'b1, 1'b0, 2'b11});
        end
    endtask

    task automatic test_bez();
        zero_flag = 1'b1;
        instruction_val = 9'h176;   // BEZ -10
        tick();
        n_vec++;
        if ({valid, branch_ctrl, branch_val} !== {1'b1, 1'b1, 8'hF6}) begin
            n_err++;
            $display("FAIL bez_taken: got %h want %h", {valid, branch_ctrl, branch_val}, {1'b1, 1'b1, 8'hF6});
        end
        instruction_val = 9'h01B;
        tick();
        n_vec++;
        if ({valid, branch_ctrl} !== 2'b00) begin
            n_err++;
            $display("FAIL bez_squash: got %b want 00", {valid, branch_ctrl});
        end
        tick();
        n_vec++;
        if ({valid, branch_ctrl} !== 2'b10) begin
            n_err++;
            $display("FAIL bez_resume: got %b want 10", {valid, branch_ctrl});
        end
        zero_flag = 1'b0;
        instruction_val = 9'h176;
        tick();
        n_vec++;
        if ({valid, branch_ctrl, branch_val, reg_we} !== {1'b1, 1'b0, 8'hF6, 1'b0}) begin
            n_err++;
            $display("FAIL bez_not_taken: got %h want %h", {valid, branch_ctrl, branch_val, reg_we},
                     {1'b1, 1'b0, 8'hF6, 1'b0});
        end
        instruction_val = 9'h0A7;
        tick();
        n_vec++;
        if ({valid, branch_ctrl, alu_op} !== {1'b1, 1'b0, 2'b10}) begin
            n_err++;
            $display("FAIL bez_no_bubble: got %b want %b", {valid, branch_ctrl, alu_op}, {1'b1, 1'b0, 2'b10});
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        zero_flag = 1'b0;
        instruction_val = 9'h194;
        tick();
        pulses += int'(branch_ctrl);
        n_vec++;
        if ({branch_ctrl, branch_val} !== {1'b1, 8'd20}) begin
            n_err++;
            $display("FAIL b2b_first: got %h want %h", {branch_ctrl, branch_val}, {1'b1, 8'd20});
        end
        instruction_val = 9'h181;   // JMP +1, lands in the flush slot
        tick();
        pulses += int'(branch_ctrl);
        n_vec++;
        if ({valid, branch_ctrl} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_second_squashed: got %b want 00", {valid, branch_ctrl});
        end
        instruction_val = 9'h01B;
        tick();
        pulses += int'(branch_ctrl);
        n_vec++;
        if (pulses !== 1 || valid !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_pulses: got pulses=%0d valid=%b want pulses=1 valid=1", pulses, valid);
        end
    endtask

    task automatic test_halt();
        instruction_val = 9'h1C0;   // NOP
        tick();
        n_vec++;
        if ({valid, reg_we, halted, branch_ctrl} !== 4'b1000) begin
            n_err++;
            $display("FAIL nop: got %b want 1000", {valid, reg_we, halted, branch_ctrl});
        end
        instruction_val = 9'h1C1;   // HALT
        tick();
        n_vec++;
        if ({valid, halted} !== 2'b10) begin
            n_err++;
            $display("FAIL halt_in_ir: got %b want 10", {valid, halted});
        end
        instruction_val = 9'h129;
        tick();
        n_vec++;
        if ({valid, halted, reg_we, branch_ctrl} !== 4'b0100) begin
            n_err++;
            $display("FAIL halt_entered: got %b want 0100", {valid, halted, reg_we, branch_ctrl});
        end
        instruction_val = 9'h194;   // ignored: IR frozen
        tick();
        tick();
        n_vec++;
        if ({valid, halted, branch_ctrl, imm_sel} !== 4'b0101) begin
            n_err++;
            $display("FAIL halt_frozen: got %b want 0101", {valid, halted, branch_ctrl, imm_sel});
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if ({valid, halted, imm_sel} !== 3'b000) begin
            n_err++;
            $display("FAIL halt_reset: got %b want 000", {valid, halted, imm_sel});
        end
        reset = 1'b1;
        instruction_val = 9'h129;   // LDI rd=2 imm=9
        tick();
        n_vec++;
        if ({valid, rd, imm, imm_sel, reg_we, halted} !== {1'b1, 2'd2, 4'd9, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL ldi_after_halt: got %b want %b", {valid, rd, imm, imm_sel, reg_we, halted},
                     {1'b1, 2'd2, 4'd9, 1'b1, 1'b1, 1'b0});
        end
    endtask

    task automatic test_reset_mid_flush();
        instruction_val = 9'h194;
        tick();
        instruction_val = 9'h01B;
        reset = 1'b0;
        tick();
        n_vec++;
        if ({valid, branch_ctrl, branch_val, halted} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_mid_flush: got %h want 0", {valid, branch_ctrl, branch_val, halted});
        end
        reset = 1'b1;
        tick();
        n_vec++;
        if ({valid, rd, rt} !== {1'b1, 2'd1, 2'd3}) begin
            n_err++;
            $display("FAIL run_after_reset: got %b want %b", {valid, rd, rt}, {1'b1, 2'd1, 2'd3});
        end
    endtask

`ifdef DECODE_BRANCH_STATS_EN
    task automatic test_stats();
        int pulses = 0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        instruction_val = 9'h194;
        for (int i = 1; i <= 15; i++) begin
            tick();
            pulses += int'(s_branch_ctrl);
            if (i == 2) begin
                n_vec++;
                if ({s_taken, s_squash} !== {2'd1, 2'd0}) begin
                    n_err++;
                    $display("FAIL stats_first: got %b want 0100", {s_taken, s_squash});
                end
            end
            if (i == 3) begin
                n_vec++;
                if (s_squash !== 2'd1) begin
                    n_err++;
                    $display("FAIL stats_squash1: got %0d want 1", s_squash);
                end
            end
        end
        n_vec++;
        if (pulses !== 5 || s_taken !== 2'd3 || s_squash !== 2'd3) begin
            n_err++;
            $display("FAIL stats_saturate: got pulses=%0d taken=%0d squash=%0d want 5 3 3",
                     pulses, s_taken, s_squash);
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if ({s_taken, s_squash, s_valid} !== 5'd0) begin
            n_err++;
            $display("FAIL stats_reset: got %b want 0", {s_taken, s_squash, s_valid});
        end
        reset = 1'b1;
        instruction_val = 9'h01B;
        tick();
        n_vec++;
        if ({s_valid, s_branch_ctrl} !== 2'b10) begin
            n_err++;
            $display("FAIL stats_run: got %b want 10", {s_valid, s_branch_ctrl});
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        instruction_val = 9'h000;
        zero_flag = 1'b0;
        test_reset();
        test_alu();
        test_jmp();
        test_bez();
        test_back_to_back();
        test_halt();
        test_reset_mid_flush();
`ifdef DECODE_BRANCH_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
